// File: rtl/pin_entry_packer.sv
// pin_entry_packer: gathers keypad digits into a PIN buffer and drives a masked
// six-digit BCD display packet. On confirm it hands the PIN to the lock
// controller as a one-cycle strobe. Every output is registered.

package pin_entry_pkg;
  // Display packet: BCD0 is the rightmost digit (HEX0); 0xA shows a dash, 0xB blanks the digit
  typedef struct packed {
    logic [3:0] BCD5;
    logic [3:0] BCD4;
    logic [3:0] BCD3;
    logic [3:0] BCD2;
    logic [3:0] BCD1;
    logic [3:0] BCD0;
  } bcdPac_t;
endpackage

module pin_entry_packer
  import pin_entry_pkg::*;
#(
  parameter int MIN_LEN        = 4,
  parameter int MASK_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int HOLD_CYCLES    = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output bcdPac_t     bcd_packet,
  output logic        enable_o,
  output logic [23:0] pin_out,
  output logic [2:0]  pin_len,
  output logic        pin_valid,
  output logic        timeout
);

  localparam int MW = $clog2(MASK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [MW-1:0] MASK_LOAD    = MW'(MASK_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    MIN_COUNT    = 3'(MIN_LEN);
  localparam logic [23:0]   EMPTY_BUF    = 24'hFFFFFF;
  localparam logic [23:0]   ALL_BLANK    = 24'hBBBBBB;
  localparam logic [23:0]   ALL_DASH     = 24'hAAAAAA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_HOLD
  } state_t;

  state_t          r_state;
  logic [23:0]     r_buf;
  logic [2:0]      r_count;
  logic [MW-1:0]   r_mask;
  logic [TW-1:0]   r_inact;
  logic [HW-1:0]   r_hold;

  logic [23:0]     r_packet;
  logic            r_enable;
  logic [23:0]     r_pinOut;
  logic [2:0]      r_pinLen;
  logic            r_pinValid;
  logic            r_timeout;

  state_t          w_nextState;
  logic [23:0]     w_nextBuf;
  logic [2:0]      w_nextCount;
  logic [MW-1:0]   w_nextMask;
  logic [TW-1:0]   w_nextInact;
  logic [HW-1:0]   w_nextHold;
  logic            w_pinValidNext;
  logic            w_timeoutNext;
  logic            w_latchPin;
  logic [23:0]     w_nextPacket;

  logic            w_isDigit;
  logic            w_isBack;
  logic            w_isConfirm;

  assign w_isDigit   = (key_code <= 4'd9);
  assign w_isBack    = (key_code == 4'hA);
  assign w_isConfirm = (key_code == 4'hB);

  // State register plus PIN buffer, digit count and the mask/inactivity/hold counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= EMPTY_BUF;
      r_count <= 3'd0;
      r_mask  <= '0;
      r_inact <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_nextState;
      r_buf   <= w_nextBuf;
      r_count <= w_nextCount;
      r_mask  <= w_nextMask;
      r_inact <= w_nextInact;
      r_hold  <= w_nextHold;
    end
  end

  // Next-state logic: key handling, inactivity expiry, hold timing; dropping active overrides all
  always_comb begin
    w_nextState    = r_state;
    w_nextBuf      = r_buf;
    w_nextCount    = r_count;
    w_nextMask     = (r_mask != '0) ? r_mask - 1'b1 : '0;
    w_nextInact    = r_inact;
    w_nextHold     = r_hold;
    w_pinValidNext = 1'b0;
    w_timeoutNext  = 1'b0;
    w_latchPin     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (active) begin
          w_nextState = S_ENTRY;
          w_nextBuf   = EMPTY_BUF;
          w_nextCount = 3'd0;
          w_nextMask  = '0;
          w_nextInact = '0;
        end
      end

      S_ENTRY: begin
        if (key_valid) begin
          w_nextInact = '0;
          if (w_isDigit && (r_count < 3'd6)) begin
            w_nextBuf   = {r_buf[19:0], key_code};
            w_nextCount = r_count + 3'd1;
            w_nextMask  = MASK_LOAD;
          end else if (w_isBack && (r_count != 3'd0)) begin
            w_nextBuf   = {4'hF, r_buf[23:4]};
            w_nextCount = r_count - 3'd1;
            w_nextMask  = '0;
          end else if (w_isConfirm && (r_count >= MIN_COUNT)) begin
            w_latchPin     = 1'b1;
            w_pinValidNext = 1'b1;
            w_nextBuf      = EMPTY_BUF;
            w_nextCount    = 3'd0;
            w_nextMask     = '0;
            w_nextHold     = '0;
            w_nextState    = S_HOLD;
          end
        end else if (r_count != 3'd0) begin
          if (r_inact == TIMEOUT_LAST) begin
            w_timeoutNext = 1'b1;
            w_nextBuf     = EMPTY_BUF;
            w_nextCount   = 3'd0;
            w_nextMask    = '0;
            w_nextInact   = '0;
          end else begin
            w_nextInact = r_inact + 1'b1;
          end
        end else begin
          w_nextInact = '0;
        end
      end

      S_HOLD: begin
        if (r_hold == HOLD_LAST) begin
          w_nextState = S_ENTRY;
          w_nextHold  = '0;
        end else begin
          w_nextHold = r_hold + 1'b1;
        end
      end

      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    if (!active) begin
      w_nextState    = S_IDLE;
      w_nextBuf      = EMPTY_BUF;
      w_nextCount    = 3'd0;
      w_nextMask     = '0;
      w_nextInact    = '0;
      w_nextHold     = '0;
      w_pinValidNext = 1'b0;
      w_timeoutNext  = 1'b0;
      w_latchPin     = 1'b0;
    end
  end

  // Display packet for the upcoming cycle: blanks past the count, dashes for older digits
  always_comb begin
    w_nextPacket = ALL_BLANK;
    if (w_nextState == S_HOLD) begin
      w_nextPacket = ALL_DASH;
    end else if (w_nextState == S_ENTRY) begin
      for (int i = 0; i < 6; i++) begin
        if (i < int'(w_nextCount)) begin
          if ((i == 0) && (w_nextMask != '0)) begin
            w_nextPacket[i*4 +: 4] = w_nextBuf[3:0];
          end else begin
            w_nextPacket[i*4 +: 4] = 4'hA;
          end
        end
      end
    end
  end

  // Output registers; the PIN result holds its value until the next accepted confirm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_packet   <= ALL_BLANK;
      r_enable   <= 1'b0;
      r_pinOut   <= EMPTY_BUF;
      r_pinLen   <= 3'd0;
      r_pinValid <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_packet   <= w_nextPacket;
      r_enable   <= (w_nextState != S_IDLE);
      r_pinValid <= w_pinValidNext;
      r_timeout  <= w_timeoutNext;
      if (w_latchPin) begin
        r_pinOut <= r_buf;
        r_pinLen <= r_count;
      end
    end
  end

  assign bcd_packet = bcdPac_t'(r_packet);
  assign enable_o   = r_enable;
  assign pin_out    = r_pinOut;
  assign pin_len    = r_pinLen;
  assign pin_valid  = r_pinValid;
  assign timeout    = r_timeout;

endmodule
